// File: rtl/seg_scan_4digit.sv
// rtl/seg_scan_4digit.sv - 4-digit multiplexed 7-segment scanner with frame-coherent load
module seg_scan_4digit #(
  parameter int SCAN_DIV    = 50000,
  parameter int DEAD_CYCLES = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  out_7seg,
  output logic        dp
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYCLES);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [19:0]   pending;
  logic [15:0]   act_digits;
  logic [3:0]    act_dp;

  logic          fb;
  logic          slot_off;
  logic [3:0]    cur_digit;
  logic [3:0]    lz;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0:    hex7 = 7'b0111111;
      4'h1:    hex7 = 7'b0000110;
      4'h2:    hex7 = 7'b1011011;
      4'h3:    hex7 = 7'b1001111;
      4'h4:    hex7 = 7'b1100110;
      4'h5:    hex7 = 7'b1101101;
      4'h6:    hex7 = 7'b1111101;
      4'h7:    hex7 = 7'b0000111;
      4'h8:    hex7 = 7'b1111111;
      4'h9:    hex7 = 7'b1101111;
      4'hA:    hex7 = 7'b1110111;
      4'hB:    hex7 = 7'b1111100;
      4'hC:    hex7 = 7'b0111001;
      4'hD:    hex7 = 7'b1011110;
      4'hE:    hex7 = 7'b1111001;
      default: hex7 = 7'b1110001;
    endcase
  endfunction

  // lz[i]: digit i and every digit above it are zero with no decimal point
  always_comb begin
    lz        = 4'b0000;
    lz[3]     = (act_digits[15:12] == 4'h0) && !act_dp[3];
    lz[2]     = lz[3] && (act_digits[11:8] == 4'h0) && !act_dp[2];
    lz[1]     = lz[2] && (act_digits[7:4] == 4'h0) && !act_dp[1];
    fb        = (cnt == CNT_LAST) && (idx == 2'd3);
    cur_digit = act_digits[{idx, 2'b00} +: 4];
    slot_off  = (cnt < CNT_DEAD) || (blank_lz && lz[idx]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt        <= '0;
      idx        <= 2'd0;
      pending    <= '0;
      act_digits <= '0;
      act_dp     <= '0;
      an         <= 4'b1111;
      out_7seg   <= 7'b0000000;
      dp         <= 1'b0;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (load)
        pending <= {digits_in, dp_in};

      // A load landing on the frame boundary goes straight to the display
      if (fb) begin
        if (load)
          {act_digits, act_dp} <= {digits_in, dp_in};
        else
          {act_digits, act_dp} <= pending;
      end

      if (slot_off) begin
        an       <= 4'b1111;
        out_7seg <= 7'b0000000;
        dp       <= 1'b0;
      end else begin
        an       <= ~(4'b0001 << idx);
        out_7seg <= hex7(cur_digit);
        dp       <= act_dp[idx];
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_4digit.sv
// tb/tb_seg_scan_4digit.sv - randomized and directed self-check of seg_scan_4digit
module tb_seg_scan_4digit;

  localparam int SD = 8;
  localparam int DC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  an;
  logic [6:0]  out_7seg;
  logic        dp;

  seg_scan_4digit #(.SCAN_DIV(SD), .DEAD_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .an(an), .out_7seg(out_7seg), .dp(dp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [6:0] hex_tab [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                               7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                               7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                               7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: t = cycles since reset release; slot/frame follow by arithmetic
  int          t = 0;
  int          slot, pos;
  bit          off, allz, started = 0;
  logic [19:0] m_pend, m_act;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;

  always @(posedge clk) begin
    started = 1;
    if (!rst) begin
      t = 0; m_pend = '0; m_act = '0;
      exp_an = 4'hF; exp_seg = '0; exp_dp = 1'b0;
    end else begin
      slot = (t / SD) % 4;
      pos  = t % SD;
      off  = (pos < DC);
      if (blank_lz && slot != 0) begin
        allz = 1;
        for (int j = slot; j < 4; j++)
          if (m_act[4 + 4*j +: 4] != 4'h0 || m_act[j]) allz = 0;
        if (allz) off = 1;
      end
      if (off) begin
        exp_an = 4'hF; exp_seg = '0; exp_dp = 1'b0;
      end else begin
        exp_an  = 4'hF;
        exp_an[slot] = 1'b0;
        exp_seg = hex_tab[m_act[4 + 4*slot +: 4]];
        exp_dp  = m_act[slot];
      end
      if (load) m_pend = {digits_in, dp_in};
      if (t % (4*SD) == 4*SD - 1) m_act = m_pend;
      t++;
    end
  end

  logic [3:0] prev_an = 4'hF;
  always @(negedge clk) begin
    if (started) begin
      chk("an", an, exp_an);
      chk("seg", out_7seg, exp_seg);
      chk("dp", dp, exp_dp);
      chk("one_anode", int'($countones(~an) <= 1), 1);
      if (prev_an != an) chk("an_via_1111", int'(prev_an == 4'hF || an == 4'hF), 1);
      prev_an = an;
    end
  end

  task automatic wait_t(input int target);
    int n = 0;
    while (t != target && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (t != target) chk("wait_t", t, target);
  endtask

  // Literal expectations pin both the DUT and the model
  task automatic pin(input string name, input logic [3:0] a, input logic [6:0] s, input logic d);
    chk({name, "_an"}, an, a);
    chk({name, "_seg"}, out_7seg, s);
    chk({name, "_dp"}, dp, d);
    chk({name, "_model"}, {exp_an, exp_seg, exp_dp}, {a, s, d});
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    digits_in = v; dp_in = d; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    repeat (3) begin
      @(negedge clk);
      digits_in = 16'($urandom); dp_in = 4'($urandom); load = 1'($urandom); blank_lz = 1'($urandom);
      pin("reset", 4'hF, 7'h00, 1'b0);
    end
    load = 1'b0; blank_lz = 1'b0; rst = 1'b1;
    wait_t(2);  pin("first_dead", 4'hF, 7'h00, 1'b0);
    wait_t(3);  pin("first_drive", 4'b1110, 7'b0111111, 1'b0);

    do_load(16'h1234, 4'b0100);
    wait_t(33); pin("t2_dead", 4'hF, 7'h00, 1'b0);
    wait_t(35); pin("t2_s0", 4'b1110, 7'b1100110, 1'b0);
    wait_t(45); pin("t2_s1", 4'b1101, 7'b1001111, 1'b0);
    wait_t(53); pin("t2_s2", 4'b1011, 7'b1011011, 1'b1);
    wait_t(61); pin("t2_s3", 4'b0111, 7'b0000110, 1'b0);

    blank_lz = 1'b1;
    do_load(16'h0050, 4'b0000);
    wait_t(69); pin("t3_s0", 4'b1110, 7'b0111111, 1'b0);
    wait_t(77); pin("t3_s1", 4'b1101, 7'b1101101, 1'b0);
    wait_t(85); pin("t3_s2", 4'hF, 7'h00, 1'b0);
    wait_t(93); pin("t3_s3", 4'hF, 7'h00, 1'b0);
    blank_lz = 1'b0;
    wait_t(94); pin("t3_nolz", 4'b0111, 7'b0111111, 1'b0);

    do_load(16'hAAAA, 4'b0000);
    wait_t(106);
    do_load(16'h5555, 4'b0000);
    wait_t(109); pin("t4_a1", 4'b1101, 7'b1110111, 1'b0);
    wait_t(125); pin("t4_a3", 4'b0111, 7'b1110111, 1'b0);
    wait_t(133); pin("t4_50", 4'b1110, 7'b1101101, 1'b0);
    wait_t(157); pin("t4_53", 4'b0111, 7'b1101101, 1'b0);

    wait_t(159);
    do_load(16'hFFFF, 4'b0000);
    wait_t(163); pin("t5_fb", 4'b1110, 7'b1110001, 1'b0);

    wait_t(213); pin("t6_pre", 4'b1011, 7'b1110001, 1'b0);
    rst = 1'b0;
    @(negedge clk); pin("t6_rst", 4'hF, 7'h00, 1'b0);
    rst = 1'b1; blank_lz = 1'b1;
    wait_t(1);  pin("t6_dead", 4'hF, 7'h00, 1'b0);
    wait_t(3);  pin("t6_d0", 4'b1110, 7'b0111111, 1'b0);
    wait_t(13); pin("t6_d1", 4'hF, 7'h00, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++)
        digits_in[4*k +: 4] = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom);
      dp_in    = ($urandom % 4 == 0) ? 4'($urandom) : 4'h0;
      load     = ($urandom % 6 == 0);
      if ($urandom % 64 == 0) blank_lz = ~blank_lz;
      rst      = ($urandom % 700 != 0);
    end
    rst = 1'b1; load = 1'b0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
